// File: rtl/mmuart_pkg.sv
// Shared types and helpers for the mmuart framer: oversampling constants,
// parity encodings, RX/TX state enums and data masking helpers.
package mmuart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_HALF = 4'(OVERSAMPLE / 2 - 1);

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  function automatic logic par_en(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

  // Clear bits above the configured character width (bits = width - 5).
  function automatic logic [7:0] data_mask(input logic [7:0] d, input logic [1:0] bits);
    return d & (8'hFF >> (2'd3 - bits));
  endfunction

  // The RX shifter fills from the top; move a short character down to bit 0.
  function automatic logic [7:0] justify(input logic [7:0] sh, input logic [1:0] bits);
    return sh >> (2'd3 - bits);
  endfunction

endpackage

// File: rtl/mmuart_baudgen.sv
// Oversampling tick generator: down-counter reloaded with divisor-1,
// tick while the counter is zero. A divisor of 0 behaves like 1.
module mmuart_baudgen #(
  parameter int DIV_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;

  always_comb reload = (divisor == '0) ? '0 : divisor - DIV_W'(1);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)       cnt <= reload;
    else if (cnt == '0)   cnt <= reload;
    else                  cnt <= cnt - DIV_W'(1);
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/mmuart_framer.sv
// UART transceiver with runtime frame format and per-character error flags.
// Optional break detection is built when MMUART_BREAK_DETECT_EN is defined.
//
// RX state   | meaning
// RX_IDLE    | line idle, waiting for a low sample on a tick
// RX_START   | counting to mid start bit; high there means glitch
// RX_DATA    | sampling data bits, LSB first
// RX_PARITY  | sampling and checking parity bit
// RX_STOP    | sampling stop bit, delivering character
// RX_WAIT_HIGH | stop was low; wait for line to return high
//
// TX state   | meaning
// TX_IDLE    | line high, accepting tx_wr
// TX_START   | sending start bit
// TX_DATA    | sending data bits, LSB first
// TX_PARITY  | sending parity bit
// TX_STOP1   | first stop bit
// TX_STOP2   | second stop bit (cfg_stop2 only)
module mmuart_framer
  import mmuart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             uart_rx,
  output logic             uart_tx,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       cfg_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic [7:0]       rx_data,
  output logic             rx_done,
  output logic             rx_perr,
  output logic             rx_ferr,
`ifdef MMUART_BREAK_DETECT_EN
  output logic             rx_break,
`endif
  input  logic [7:0]       tx_data,
  input  logic             tx_wr,
  output logic             tx_busy,
  output logic             tx_done
);

  logic tick;

  mmuart_baudgen #(.DIV_W(DIV_W)) u_baud (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .divisor  (divisor),
    .tick     (tick)
  );

  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) rx_sync <= '1;
    else            rx_sync <= {rx_sync[SYNC_STAGES-2:0], uart_rx};
  end

  assign rx_s = rx_sync[SYNC_STAGES-1];

  rx_state_t  rx_state;
  logic [3:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic [1:0] rx_bits;
  logic [1:0] rx_par;
  logic       rx_perr_q;
`ifdef MMUART_BREAK_DETECT_EN
  logic       rx_zero;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_bits   <= '0;
      rx_par    <= PAR_NONE;
      rx_perr_q <= 1'b0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_perr   <= 1'b0;
      rx_ferr   <= 1'b0;
`ifdef MMUART_BREAK_DETECT_EN
      rx_zero   <= 1'b0;
      rx_break  <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
`ifdef MMUART_BREAK_DETECT_EN
      rx_break <= 1'b0;
`endif
      if (tick) begin
        case (rx_state)
          RX_IDLE: if (!rx_s) begin
            rx_state  <= RX_START;
            rx_cnt    <= OS_HALF;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_bits   <= cfg_bits;
            rx_par    <= cfg_parity;
            rx_perr_q <= 1'b0;
`ifdef MMUART_BREAK_DETECT_EN
            rx_zero   <= 1'b1;
`endif
          end
          RX_WAIT_HIGH: if (rx_s) rx_state <= RX_IDLE;
          default: begin
            if (rx_cnt != '0) begin
              rx_cnt <= rx_cnt - 4'd1;
            end else begin
              rx_cnt <= OS_LAST;
              case (rx_state)
                RX_START: rx_state <= rx_s ? RX_IDLE : RX_DATA;
                RX_DATA: begin
                  rx_sh <= {rx_s, rx_sh[7:1]};
`ifdef MMUART_BREAK_DETECT_EN
                  if (rx_s) rx_zero <= 1'b0;
`endif
                  if (rx_bit == {1'b0, rx_bits} + 3'd4)
                    rx_state <= par_en(rx_par) ? RX_PARITY : RX_STOP;
                  else
                    rx_bit <= rx_bit + 3'd1;
                end
                RX_PARITY: begin
                  rx_perr_q <= rx_s != (^justify(rx_sh, rx_bits) ^ (rx_par == PAR_ODD));
`ifdef MMUART_BREAK_DETECT_EN
                  if (rx_s) rx_zero <= 1'b0;
`endif
                  rx_state <= RX_STOP;
                end
                RX_STOP: begin
                  rx_data  <= justify(rx_sh, rx_bits);
                  rx_perr  <= rx_perr_q;
                  rx_ferr  <= !rx_s;
                  rx_done  <= 1'b1;
`ifdef MMUART_BREAK_DETECT_EN
                  rx_break <= rx_zero && !rx_s;
`endif
                  rx_state <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end
                default: rx_state <= RX_IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

  tx_state_t  tx_state;
  logic [3:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic [1:0] tx_bits;
  logic       tx_par_en;
  logic       tx_par_bit;
  logic       tx_stop2;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_sh      <= '0;
      tx_bits    <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_stop2   <= 1'b0;
      uart_tx    <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_state == TX_IDLE) begin
        if (tx_wr) begin
          tx_state   <= TX_START;
          tx_sh      <= data_mask(tx_data, cfg_bits);
          tx_par_bit <= ^data_mask(tx_data, cfg_bits) ^ (cfg_parity == PAR_ODD);
          tx_bits    <= cfg_bits;
          tx_par_en  <= par_en(cfg_parity);
          tx_stop2   <= cfg_stop2;
          tx_cnt     <= OS_LAST;
          tx_bit     <= '0;
          uart_tx    <= 1'b0;
          tx_busy    <= 1'b1;
        end
      end else if (tick) begin
        if (tx_cnt != '0) begin
          tx_cnt <= tx_cnt - 4'd1;
        end else begin
          tx_cnt <= OS_LAST;
          case (tx_state)
            TX_START: begin
              tx_state <= TX_DATA;
              uart_tx  <= tx_sh[0];
            end
            TX_DATA: begin
              if (tx_bit == {1'b0, tx_bits} + 3'd4) begin
                tx_state <= tx_par_en ? TX_PARITY : TX_STOP1;
                uart_tx  <= tx_par_en ? tx_par_bit : 1'b1;
              end else begin
                tx_bit  <= tx_bit + 3'd1;
                tx_sh   <= tx_sh >> 1;
                uart_tx <= tx_sh[1];
              end
            end
            TX_PARITY: begin
              tx_state <= TX_STOP1;
              uart_tx  <= 1'b1;
            end
            TX_STOP1: begin
              if (tx_stop2) begin
                tx_state <= TX_STOP2;
              end else begin
                tx_state <= TX_IDLE;
                tx_busy  <= 1'b0;
                tx_done  <= 1'b1;
              end
            end
            default: begin
              tx_state <= TX_IDLE;
              uart_tx  <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule
